// File: rtl/fetch_pc_gen_if.sv
// Fetch request channel between the PC generator and the IF stage.
//   fetch_valid  gen -> IF   request valid
//   fetch_ready  IF  -> gen  IF accepts; accept = fetch_valid & fetch_ready
//   fetch_pc     gen -> IF   request address (XLEN)
//   fetch_mask   gen -> IF   live slots of the fetch group (FETCH_WIDTH)
//   fetch_epoch  gen -> IF   redirect epoch tag (EPOCH_W)
//   fetch_adef   gen -> IF   request address misaligned
interface fetch_pc_gen_if #(
  parameter int XLEN        = 32,
  parameter int FETCH_WIDTH = 1,
  parameter int EPOCH_W     = 2
);
  logic                   fetch_valid;
  logic                   fetch_ready;
  logic [XLEN-1:0]        fetch_pc;
  logic [FETCH_WIDTH-1:0] fetch_mask;
  logic [EPOCH_W-1:0]     fetch_epoch;
  logic                   fetch_adef;

  modport master (
    output fetch_valid, fetch_pc, fetch_mask, fetch_epoch, fetch_adef,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_mask, fetch_epoch, fetch_adef,
    output fetch_ready
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator. Issues one aligned fetch group of FETCH_WIDTH
// instructions per accepted request, takes exception/branch redirects
// (exception wins), tags requests with a redirect epoch, flags misaligned
// targets and supports an IDLE halt with wake-up.
// Ports:
//   clk          in   clock, rising edge
//   rstn         in   synchronous active-low reset
//   fetch        master modport of fetch_pc_gen_if (request channel to IF)
//   ex_redirect  in   exception/ertn redirect, highest priority
//   ex_target    in   exception redirect target
//   br_redirect  in   branch-mispredict redirect (RUN only)
//   br_target    in   branch redirect target
//   idle_req     in   idle instruction committed, halt fetch
//   wake         in   interrupt pending, leave IDLE
module fetch_pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h1c000000,
  parameter int              FETCH_WIDTH = 1,
  parameter int              EPOCH_W     = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  fetch_pc_gen_if.master       fetch,
  input  logic                 ex_redirect,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 br_redirect,
  input  logic [XLEN-1:0]      br_target,
  input  logic                 idle_req,
  input  logic                 wake
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_IDLE,
    S_WAIT_EX
  } state_t;

  localparam logic [XLEN-1:0] GRP_BYTES = XLEN'(4 * FETCH_WIDTH);

  state_t                 r_state;
  logic                   r_valid;
  logic [XLEN-1:0]        r_pc;
  logic [FETCH_WIDTH-1:0] r_mask;
  logic [EPOCH_W-1:0]     r_epoch;
  logic                   r_adef;

  state_t                 w_nxt_state;
  logic [XLEN-1:0]        w_nxt_pc;
  logic [EPOCH_W-1:0]     w_nxt_epoch;
  logic                   w_nxt_adef;
  logic                   w_accept;
  logic                   w_redir;
  logic [XLEN-1:0]        w_target;
  logic [XLEN-1:0]        w_seq_pc;

  // Slot i is live when it sits at or after the entry slot of the group.
  function automatic logic [FETCH_WIDTH-1:0] mask_of(input logic [XLEN-1:0] pc);
    logic [FETCH_WIDTH-1:0] m;
    logic [XLEN-1:0]        off;
    off = (pc >> 2) & XLEN'(FETCH_WIDTH - 1);
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      m[i] = (XLEN'(i) >= off);
    end
    return m;
  endfunction

  assign w_accept = r_valid & fetch.fetch_ready;
  assign w_target = ex_redirect ? ex_target : br_target;
  // Branch redirects only matter while fetching; ex works in any live state.
  assign w_redir  = ex_redirect | (br_redirect & (r_state == S_RUN));
  assign w_seq_pc = (r_pc & ~(GRP_BYTES - XLEN'(1))) + GRP_BYTES;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc;
    w_nxt_epoch = r_epoch;
    w_nxt_adef  = r_adef;
    if (r_state != S_BOOT && w_redir) begin
      w_nxt_pc    = w_target;
      w_nxt_epoch = r_epoch + EPOCH_W'(1);
      w_nxt_adef  = (w_target[1:0] != 2'b00);
      // A branch applied together with idle_req still halts; ex never does.
      if (r_state == S_RUN && !ex_redirect && idle_req) begin
        w_nxt_state = S_IDLE;
      end else begin
        w_nxt_state = S_RUN;
      end
    end else begin
      case (r_state)
        S_BOOT: w_nxt_state = S_RUN;
        S_RUN: begin
          if (idle_req) begin
            w_nxt_state = S_IDLE;
          end else if (w_accept) begin
            if (r_adef) begin
              w_nxt_state = S_WAIT_EX;
            end else begin
              w_nxt_pc   = w_seq_pc;
              w_nxt_adef = 1'b0;
            end
          end
        end
        S_IDLE: begin
          if (wake) w_nxt_state = S_RUN;
        end
        S_WAIT_EX: w_nxt_state = S_WAIT_EX;
        default:   w_nxt_state = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_BOOT;
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_mask  <= mask_of(RESET_PC);
      r_epoch <= '0;
      r_adef  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_valid <= (w_nxt_state == S_RUN);
      r_pc    <= w_nxt_pc;
      r_mask  <= mask_of(w_nxt_pc);
      r_epoch <= w_nxt_epoch;
      r_adef  <= w_nxt_adef;
    end
  end

  assign fetch.fetch_valid = r_valid;
  assign fetch.fetch_pc    = r_pc;
  assign fetch.fetch_mask  = r_mask;
  assign fetch.fetch_epoch = r_epoch;
  assign fetch.fetch_adef  = r_adef;

endmodule
